// File: rtl/scandoubler_vidin.sv
// scandoubler_vidin: write-side feeder for the scandoubler SDRAM framebuffer.
// Packs the qualified pixel stream into 8-word bursts held in a two-entry
// ping-pong buffer and offers them on the vidin_* burst-write handshake.
//
// Handshake: vidin_req rises when an entry is full and stays high until the
// 8th vidin_ack; each ack sampled high advances one word, and vidin_d/vidin_x
// present that word on the cycle after the ack. Acks seen with req low are
// ignored.
//
// Optional feature: define SCANDOUBLER_VIDIN_FLUSH_EN to pad a partially
// filled entry with zeros on an hs/vs rising edge and drain it; otherwise a
// partial entry is discarded at sync.
module scandoubler_vidin #(
  parameter int XW = 11
) (
  input  logic          clk_96,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic [15:0]   pix_d,
  input  logic          hs,
  input  logic          vs,
  output logic          vidin_req,
  output logic [1:0]    vidin_frame,
  output logic [XW-1:0] vidin_x,
  output logic [XW-1:0] vidin_y,
  output logic [15:0]   vidin_d,
  input  logic          vidin_ack,
  output logic          overflow
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        state;
  logic [2:0]    ptr;

  logic          hs_d, vs_d;
  logic          hs_rise, vs_rise;
  logic [XW-1:0] wx, wy;
  logic [1:0]    frame;

  logic [15:0]   mem [0:15];
  logic [1:0]    full;
  logic          fill_sel, drain_sel;
  logic [XW-1:0] hdr_x [0:1];
  logic [XW-1:0] hdr_y [0:1];
  logic [1:0]    hdr_f [0:1];

  logic [2:0]    idx;
  logic          pix_store;
  logic          fill_done;
  logic          release_burst;
  logic [1:0]    full_set, full_clr;

  assign hs_rise   = hs & ~hs_d;
  assign vs_rise   = vs & ~vs_d;
  assign idx       = wx[2:0];
  assign pix_store = pix_ce & ~full[fill_sel];

`ifdef SCANDOUBLER_VIDIN_FLUSH_EN
  logic flush;
  // A sync edge closes a partial entry early, as long as there is room for it.
  assign flush     = (hs_rise | vs_rise) & (idx != 3'd0) & ~full[fill_sel];
  assign fill_done = (pix_store & (idx == 3'd7)) | flush;
`else
  assign fill_done = pix_store & (idx == 3'd7);
`endif

  assign release_burst = (state == S_BURST) & vidin_ack & (ptr == 3'd7);
  assign full_set      = fill_done     ? (fill_sel  ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr      = release_burst ? (drain_sel ? 2'b10 : 2'b01) : 2'b00;

  // One-cycle registered copies of the sync inputs for edge detection.
  always_ff @(posedge clk_96) begin
    if (reset) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      hs_d <= hs;
      vs_d <= vs;
    end
  end

  // Input geometry counters; dropped pixels still advance x.
  always_ff @(posedge clk_96) begin
    if (reset) begin
      wx    <= '0;
      wy    <= '0;
      frame <= 2'd0;
    end else begin
      if (pix_ce)
        wx <= wx + 1'b1;
      if (hs_rise) begin
        wx <= '0;
        wy <= wy + 1'b1;
      end
      if (vs_rise) begin
        wx    <= '0;
        wy    <= '0;
        frame <= frame + 2'd1;
      end
    end
  end

  // Pixel storage into the fill entry (zero padding on an early close).
  always_ff @(posedge clk_96) begin
    if (!reset) begin
      if (pix_store)
        mem[{fill_sel, idx}] <= pix_d;
`ifdef SCANDOUBLER_VIDIN_FLUSH_EN
      if (flush) begin
        for (int i = 0; i < 8; i++) begin
          if (3'(i) >= idx)
            mem[{fill_sel, 3'(i)}] <= 16'h0000;
        end
      end
`endif
    end
  end

  // Entry headers, fill pointer swap and the sticky overflow flag.
  always_ff @(posedge clk_96) begin
    if (reset) begin
      fill_sel <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pix_ce && full[fill_sel])
        overflow <= 1'b1;
      if (fill_done) begin
        fill_sel        <= ~fill_sel;
        hdr_x[fill_sel] <= {wx[XW-1:3], 3'b000};
        hdr_y[fill_sel] <= wy;
        hdr_f[fill_sel] <= frame;
      end
    end
  end

  // Entry full flags: set by the filler, cleared by the drain on the 8th ack.
  always_ff @(posedge clk_96) begin
    if (reset)
      full <= 2'b00;
    else
      full <= (full & ~full_clr) | full_set;
  end

  // Read FSM: offer the drain entry and step one word per ack.
  always_ff @(posedge clk_96) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= 3'd0;
      drain_sel   <= 1'b0;
      vidin_req   <= 1'b0;
      vidin_d     <= 16'h0000;
      vidin_x     <= '0;
      vidin_y     <= '0;
      vidin_frame <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (full[drain_sel]) begin
            vidin_req   <= 1'b1;
            vidin_x     <= hdr_x[drain_sel];
            vidin_y     <= hdr_y[drain_sel];
            vidin_frame <= hdr_f[drain_sel];
            ptr         <= 3'd0;
            state       <= S_BURST;
          end
        end
        S_BURST: begin
          if (vidin_ack) begin
            vidin_d <= mem[{drain_sel, ptr}];
            vidin_x <= hdr_x[drain_sel] + XW'(ptr);
            ptr     <= ptr + 3'd1;
            if (ptr == 3'd7) begin
              vidin_req <= 1'b0;
              drain_sel <= ~drain_sel;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scandoubler_vidin.sv
// tb_scandoubler_vidin: randomized scoreboard bench for scandoubler_vidin.
// A stream-level model turns every pixel/sync into expected burst words
// {frame, y, x, data}; a monitor pops one per ack-response cycle.
module tb_scandoubler_vidin;

  logic        clk_96 = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic [15:0] pix_d;
  logic        hs, vs;
  logic        vidin_req;
  logic [1:0]  vidin_frame;
  logic [10:0] vidin_x, vidin_y;
  logic [15:0] vidin_d;
  logic        vidin_ack;
  logic        overflow;

  // Clock / reset block
  always #5 clk_96 = ~clk_96;

  scandoubler_vidin #(.XW(11)) dut (
    .clk_96      (clk_96),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .pix_d       (pix_d),
    .hs          (hs),
    .vs          (vs),
    .vidin_req   (vidin_req),
    .vidin_frame (vidin_frame),
    .vidin_x     (vidin_x),
    .vidin_y     (vidin_y),
    .vidin_d     (vidin_d),
    .vidin_ack   (vidin_ack),
    .overflow    (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [39:0] exp_q[$];

  // Reference model state (stream level)
  int          m_wx, m_wy, m_frame, m_nout;
  logic [15:0] m_part [8];

  // Controller emulation knobs
  bit ack_en    = 1'b0;
  bit ack_gaps  = 1'b0;
  int ack_limit = 8;
  bit aborted   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_wx = 0; m_wy = 0; m_frame = 0; m_nout = 0;
    for (int i = 0; i < 8; i++) m_part[i] = 16'h0000;
  endfunction

  function automatic void model_push(input int base);
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  f;
      logic [10:0] y, x;
      f = m_frame[1:0];
      y = m_wy[10:0];
      x = 11'(base + i);
      exp_q.push_back({f, y, x, m_part[i]});
    end
    m_nout++;
  endfunction

  function automatic void model_pixel(input logic [15:0] d);
    int k;
    k = m_wx % 8;
    if (m_nout < 2) begin
      m_part[k] = d;
      if (k == 7) model_push(m_wx - 7);
    end
    m_wx = (m_wx + 1) % 2048;
  endfunction

  function automatic void model_sync(input bit is_vs);
`ifdef SCANDOUBLER_VIDIN_FLUSH_EN
    if ((m_wx % 8) != 0 && m_nout < 2) begin
      for (int i = m_wx % 8; i < 8; i++) m_part[i] = 16'h0000;
      model_push(m_wx - (m_wx % 8));
    end
`endif
    if (is_vs) begin
      m_wy    = 0;
      m_frame = (m_frame + 1) % 4;
    end else begin
      m_wy = (m_wy + 1) % 2048;
    end
    m_wx = 0;
  endfunction

  // Driver tasks (all start and end 1 time unit after a rising edge)
  task automatic send_pixel(input logic [15:0] d, input int gap);
    repeat (gap - 1) begin @(posedge clk_96); #1; end
    pix_ce = 1'b1;
    pix_d  = d;
    model_pixel(d);
    @(posedge clk_96); #1;
    pix_ce = 1'b0;
  endtask

  task automatic do_sync(input bit is_vs);
    if (is_vs) vs = 1'b1; else hs = 1'b1;
    model_sync(is_vs);
    repeat (2) begin @(posedge clk_96); #1; end
    hs = 1'b0;
    vs = 1'b0;
    repeat (60) begin @(posedge clk_96); #1; end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk_96); #1; end
    exp_q.delete();
    model_reset();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || vidin_req) && t < 3000) begin
      @(posedge clk_96); #1;
      t++;
    end
    check({name, "_drain_timeout"}, (t >= 3000), 1'b0);
  endtask

  // Controller: acks offered bursts, optionally with gaps or cut short
  task automatic run_burst();
    int n = ack_limit;
    int t = 0;
    for (int k = 0; k < n; k++) begin
      if (ack_gaps) begin
        repeat ($urandom_range(0, 2)) begin
          vidin_ack = 1'b0;
          @(posedge clk_96); #1;
        end
      end
      vidin_ack = 1'b1;
      @(posedge clk_96); #1;
    end
    vidin_ack = 1'b0;
    if (n == 8) begin
      check("req_fall", vidin_req, 1'b0);
      m_nout--;
    end else begin
      aborted = 1'b1;
    end
    while (vidin_req && t < 50) begin
      @(posedge clk_96); #1;
      t++;
    end
  endtask

  initial begin
    vidin_ack = 1'b0;
    forever begin
      @(posedge clk_96); #1;
      if (ack_en && vidin_req && !reset) run_burst();
    end
  end

  // Scoreboard monitor: one expected word per acked cycle, checked mid-cycle
  logic ack_q = 1'b0, req_q = 1'b0, rst_q = 1'b1;
  always @(posedge clk_96) begin
    ack_q <= vidin_ack;
    req_q <= vidin_req;
    rst_q <= reset;
  end

  always @(negedge clk_96) begin
    if (ack_q && req_q && !rst_q) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL burst_word: unexpected word %0h with empty queue at %0t",
                 {vidin_frame, vidin_y, vidin_x, vidin_d}, $time);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("burst_word", {vidin_frame, vidin_y, vidin_x, vidin_d}, e);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    int t;
    reset  = 1'b1;
    pix_ce = 1'b0;
    pix_d  = 16'h0000;
    hs     = 1'b0;
    vs     = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk_96); #1; end

    // Reset values
    check("rst_req",      vidin_req,   1'b0);
    check("rst_d",        vidin_d,     16'h0000);
    check("rst_x",        vidin_x,     11'd0);
    check("rst_y",        vidin_y,     11'd0);
    check("rst_frame",    vidin_frame, 2'd0);
    check("rst_overflow", overflow,    1'b0);
    reset = 1'b0;

    // First burst: 1..8, request latency, back-to-back acks
    for (int i = 1; i <= 8; i++) send_pixel(16'(i), 8);
    check("req_latency_n1", vidin_req, 1'b0);
    @(posedge clk_96); #1;
    check("req_latency_n2", vidin_req, 1'b1);
    ack_en = 1'b1;
    wait_drain("first");

    // Overflow: 24 pixels with acks withheld
    ack_en = 1'b0;
    apply_reset();
    for (int i = 0; i < 24; i++) send_pixel(16'($urandom_range(0, 65535)), 8);
    check("overflow_set", overflow,  1'b1);
    check("req_pending",  vidin_req, 1'b1);
    ack_gaps = 1'b1;
    ack_en   = 1'b1;
    wait_drain("overflow");
    check("overflow_sticky", overflow, 1'b1);

    // Line sync after 16 pixels, then a new line
    apply_reset();
    for (int i = 0; i < 16; i++) send_pixel(16'($urandom_range(0, 65535)), $urandom_range(8, 12));
    do_sync(1'b0);
    for (int i = 0; i < 8; i++) send_pixel(16'($urandom_range(0, 65535)), $urandom_range(8, 12));
    wait_drain("hs_line");

    // Random frames: 3 lines each, random widths, frame index wraps
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      for (int l = 0; l < 3; l++) begin
        int len;
        len = $urandom_range(8, 30);
        for (int p = 0; p < len; p++)
          send_pixel(16'($urandom_range(0, 65535)), $urandom_range(8, 12));
        do_sync(1'b0);
      end
      do_sync(1'b1);
    end
    wait_drain("random");
    check("no_overflow_random", overflow, 1'b0);

    // Partial line: 5 pixels then hs
    ack_en = 1'b0;
    apply_reset();
    for (int i = 1; i <= 5; i++) send_pixel(16'(16'h0100 + i), 8);
    do_sync(1'b0);
`ifdef SCANDOUBLER_VIDIN_FLUSH_EN
    check("partial_req", vidin_req, 1'b1);
`else
    check("partial_req", vidin_req, 1'b0);
`endif
    ack_en = 1'b1;
    wait_drain("partial");
    for (int i = 0; i < 8; i++) send_pixel(16'($urandom_range(0, 65535)), 8);
    wait_drain("after_partial");

    // Reset after 3 acks of a burst
    ack_en = 1'b0;
    apply_reset();
    ack_limit = 3;
    ack_gaps  = 1'b0;
    ack_en    = 1'b1;
    for (int i = 0; i < 8; i++) send_pixel(16'($urandom_range(0, 65535)), 8);
    t = 0;
    while (!aborted && t < 100) begin
      @(posedge clk_96); #1;
      t++;
    end
    check("abort_timeout", (t >= 100), 1'b0);
    ack_en    = 1'b0;
    ack_limit = 8;
    reset     = 1'b1;
    @(posedge clk_96); #1;
    exp_q.delete();
    model_reset();
    check("abort_req", vidin_req, 1'b0);
    check("abort_d",   vidin_d,   16'h0000);
    reset = 1'b0;
    ack_en = 1'b1;
    for (int i = 0; i < 8; i++) send_pixel(16'($urandom_range(0, 65535)), 8);
    wait_drain("after_abort");

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
